// File: rtl/wash_program_sequencer.sv
// Washing-machine cycle sequencer: latches a program on start and steps through
// fill, wash, rinse, drain and spin with per-phase timers, door hold and abort-drain.
module wash_program_sequencer #(
    parameter int CW      = 12,
    parameter int FILL_T  = 120,
    parameter int WASH_T  = 1200,
    parameter int RINSE_T = 600,
    parameter int DRAIN_T = 180,
    parameter int SPIN_T  = 300
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    prog,
    input  logic          door_closed,
    input  logic          abort,
    output logic [2:0]    phase,
    output logic          valve_in,
    output logic          motor_wash,
    output logic          motor_spin,
    output logic          pump,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_DRAIN = 3'd4,
        S_SPIN  = 3'd5,
        S_DONE  = 3'd6,
        S_HOLD  = 3'd7
    } state_t;

    state_t        state, state_nxt;
    state_t        saved, saved_nxt;
    logic [CW-1:0] timer, timer_nxt;
    logic [1:0]    prog_q, prog_nxt;
    logic          aborted, aborted_nxt;
    logic          pass, pass_nxt;
    logic          quick;

    // Timer load value for a phase: duration minus one, so the phase lasts D cycles.
    function automatic logic [CW-1:0] load_val(input state_t s, input logic q);
        logic [CW-1:0] d;
        case (s)
            S_FILL:  d = CW'(FILL_T);
            S_WASH:  d = CW'(WASH_T);
            S_RINSE: d = CW'(RINSE_T);
            S_DRAIN: d = CW'(DRAIN_T);
            default: d = CW'(SPIN_T);
        endcase
        if (q) d = ((d >> 1) == '0) ? CW'(1) : (d >> 1);
        return d - CW'(1);
    endfunction

    assign quick = (prog_q == 2'b01);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the memory-free datapath is fully reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            saved   <= S_IDLE;
            timer   <= '0;
            prog_q  <= '0;
            aborted <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state   <= state_nxt;
            saved   <= saved_nxt;
            timer   <= timer_nxt;
            prog_q  <= prog_nxt;
            aborted <= aborted_nxt;
            pass    <= pass_nxt;
        end
    end

    // NOTE: every signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        saved_nxt   = saved;
        timer_nxt   = timer;
        prog_nxt    = prog_q;
        aborted_nxt = aborted;
        pass_nxt    = pass;
        case (state)
            S_IDLE: begin
                if (start && door_closed) begin
                    prog_nxt = prog;
                    if (prog == 2'b11) begin
                        state_nxt = S_DRAIN;
                        timer_nxt = load_val(S_DRAIN, 1'b0);
                    end else begin
                        state_nxt = S_FILL;
                        timer_nxt = load_val(S_FILL, prog == 2'b01);
                    end
                end
            end
            S_FILL, S_WASH, S_RINSE: begin
                if (abort) begin
                    state_nxt   = S_DRAIN;
                    timer_nxt   = load_val(S_DRAIN, quick);
                    aborted_nxt = 1'b1;
                end else if (!door_closed) begin
                    state_nxt = S_HOLD;
                    saved_nxt = state;
                end else if (timer == '0) begin
                    if (state == S_FILL) state_nxt = S_WASH;
                    else if (state == S_WASH) state_nxt = S_RINSE;
                    else if (prog_q == 2'b10 && !pass) begin
                        state_nxt = S_RINSE;
                        pass_nxt  = 1'b1;
                    end else state_nxt = S_DRAIN;
                    timer_nxt = load_val(state_nxt, quick);
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end
            S_DRAIN: begin
                if (abort) aborted_nxt = 1'b1;
                if (timer == '0) begin
                    if (aborted || abort) begin
                        state_nxt   = S_IDLE;
                        timer_nxt   = '0;
                        aborted_nxt = 1'b0;
                        pass_nxt    = 1'b0;
                    end else begin
                        state_nxt = S_SPIN;
                        timer_nxt = load_val(S_SPIN, quick);
                    end
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end
            S_SPIN: begin
                if (abort) begin
                    state_nxt   = S_IDLE;
                    timer_nxt   = '0;
                    aborted_nxt = 1'b0;
                    pass_nxt    = 1'b0;
                end else if (!door_closed) begin
                    state_nxt = S_HOLD;
                    saved_nxt = state;
                end else if (timer == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_nxt   = S_DRAIN;
                    timer_nxt   = load_val(S_DRAIN, quick);
                    aborted_nxt = 1'b1;
                end else if (door_closed) begin
                    state_nxt = saved;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                timer_nxt   = '0;
                aborted_nxt = 1'b0;
                pass_nxt    = 1'b0;
            end
        endcase
    end

    assign phase      = state;
    assign valve_in   = (state == S_FILL);
    assign motor_wash = (state == S_WASH) || (state == S_RINSE);
    assign motor_spin = (state == S_SPIN);
    assign pump       = (state == S_DRAIN);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign remaining  = (state == S_IDLE || state == S_DONE) ? '0 : timer;

endmodule
